// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with IF/ID latch.
// Owns the PC, issues imem reads, latches instruction and PC+4 for decode, and
// handles stalls, redirects (including one landing while a fetch is outstanding)
// and the sticky halt.
// Optional macro FETCH_PERF_CNT_EN enables the fetch_count / stall_cycles counters;
// without it both ports are tied to zero.
module fetch_unit #(
   parameter logic [31:0] PC_INIT = 32'h00000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ihit,
   input  logic [31:0] imemload,
   output logic        imemREN,
   output logic [31:0] imemaddr,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt_in,
   output logic [31:0] if_instr,
   output logic [31:0] if_npc,
   output logic        if_valid,
   output logic        halted,
   output logic [31:0] fetch_count,
   output logic [31:0] stall_cycles
);

   typedef enum logic [1:0] {StFetch, StRedirPend, StHalted} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_pc_q, pend_pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_npc_q, if_npc_d;
   logic        if_valid_q, if_valid_d;
   logic        halted_q, halted_d;
   logic [31:0] redir_tgt;
   logic [31:0] pc_plus4;
   logic        load_valid;

   assign redir_tgt = {redirect_pc[31:2], 2'b00};
   assign pc_plus4  = pc_q + 32'd4;

   // Next-state: priority redirect > halt > stall > ihit within FETCH.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_pc_d  = pend_pc_q;
      if_instr_d = if_instr_q;
      if_npc_d   = if_npc_q;
      if_valid_d = if_valid_q;
      halted_d   = halted_q;
      load_valid = 1'b0;
      unique case (state_q)
         StFetch: begin
            if (redirect_valid) begin
               if_valid_d = 1'b0;
               if_instr_d = 32'h0;
               if (ihit) begin
                  pc_d = redir_tgt;
               end else begin
                  pend_pc_d = redir_tgt;
                  state_d   = StRedirPend;
               end
            end else if (halt_in) begin
               state_d    = StHalted;
               halted_d   = 1'b1;
               if_valid_d = 1'b0;
            end else if (stall) begin
               // Hold everything; any returned word is refetched later.
            end else if (ihit) begin
               if_instr_d = imemload;
               if_npc_d   = pc_plus4;
               if_valid_d = 1'b1;
               pc_d       = pc_plus4;
               load_valid = 1'b1;
            end else begin
               if_instr_d = 32'h0;
               if_valid_d = 1'b0;
            end
         end
         StRedirPend: begin
            // Old fetch still in flight on the old PC; its word is dropped.
            if_valid_d = 1'b0;
            if (redirect_valid) pend_pc_d = redir_tgt;
            if (ihit) begin
               pc_d    = redirect_valid ? redir_tgt : pend_pc_q;
               state_d = StFetch;
            end
         end
         StHalted: begin
         end
         default: state_d = StFetch;
      endcase
   end

   // State and IF/ID registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= StFetch;
         pc_q       <= PC_INIT;
         pend_pc_q  <= 32'h0;
         if_instr_q <= 32'h0;
         if_npc_q   <= 32'h0;
         if_valid_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_pc_q  <= pend_pc_d;
         if_instr_q <= if_instr_d;
         if_npc_q   <= if_npc_d;
         if_valid_q <= if_valid_d;
         halted_q   <= halted_d;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q;

   // Perf counters; both naturally freeze outside FETCH.
   always_ff @(posedge CLK) begin
      if (RST) begin
         fetch_cnt_q <= 32'h0;
         stall_cnt_q <= 32'h0;
      end else begin
         if (load_valid) fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall && state_q == StFetch) stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_count  = fetch_cnt_q;
   assign stall_cycles = stall_cnt_q;
`else
   logic unused_load_valid;
   assign unused_load_valid = load_valid;
   assign fetch_count  = 32'h0;
   assign stall_cycles = 32'h0;
`endif

   assign imemaddr = pc_q;
   assign imemREN  = (state_q != StHalted);
   assign if_instr = if_instr_q;
   assign if_npc   = if_npc_q;
   assign if_valid = if_valid_q;
   assign halted   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit (PC_INIT = 0x100), hand-computed expectations.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST, ihit, stall, redirect_valid, halt_in;
   logic [31:0] imemload, redirect_pc;
   logic        imemREN, if_valid, halted;
   logic [31:0] imemaddr, if_instr, if_npc, fetch_count, stall_cycles;

   int errors = 0;
   int checks = 0;

`ifdef FETCH_PERF_CNT_EN
   localparam bit Perf = 1'b1;
`else
   localparam bit Perf = 1'b0;
`endif

   fetch_unit #(.PC_INIT(32'h100)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload), .imemREN(imemREN),
      .imemaddr(imemaddr), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .halt_in(halt_in), .if_instr(if_instr),
      .if_npc(if_npc), .if_valid(if_valid), .halted(halted),
      .fetch_count(fetch_count), .stall_cycles(stall_cycles)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle before sampling.
   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST = 1'b1; ihit = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt_in = 1'b0;
      imemload = 32'h0; redirect_pc = 32'h0;
      step(); step();
      check("rst_addr", imemaddr, 32'h100);
      check("rst_ren", {31'b0, imemREN}, 32'd1);
      check("rst_valid", {31'b0, if_valid}, 32'd0);
      check("rst_instr", if_instr, 32'h0);
      check("rst_npc", if_npc, 32'h0);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_fcnt", fetch_count, 32'h0);

      // Back-to-back hits
      RST = 1'b0; ihit = 1'b1; imemload = 32'h20010005;
      step();
      check("f1_instr", if_instr, 32'h20010005);
      check("f1_npc", if_npc, 32'h104);
      check("f1_valid", {31'b0, if_valid}, 32'd1);
      check("f1_addr", imemaddr, 32'h104);
      imemload = 32'h20020007;
      step();
      check("f2_instr", if_instr, 32'h20020007);
      check("f2_npc", if_npc, 32'h108);
      check("f2_addr", imemaddr, 32'h108);

      // Misses insert bubbles, address held
      ihit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("miss_addr", imemaddr, 32'h108);
         check("miss_valid", {31'b0, if_valid}, 32'd0);
         check("miss_instr", if_instr, 32'h0);
      end
      ihit = 1'b1; imemload = 32'h11111111;
      step();
      check("miss_hit_instr", if_instr, 32'h11111111);
      check("miss_hit_npc", if_npc, 32'h10C);
      check("miss_hit_addr", imemaddr, 32'h10C);

      // Stall holds PC and IF/ID even with ihit
      stall = 1'b1; imemload = 32'h22222222;
      for (int i = 0; i < 2; i++) begin
         step();
         check("stall_addr", imemaddr, 32'h10C);
         check("stall_instr", if_instr, 32'h11111111);
         check("stall_valid", {31'b0, if_valid}, 32'd1);
      end
      stall = 1'b0;
      step();
      check("post_stall_instr", if_instr, 32'h22222222);
      check("post_stall_npc", if_npc, 32'h110);
      check("post_stall_addr", imemaddr, 32'h110);
      check("stall_cycles", stall_cycles, Perf ? 32'd2 : 32'd0);
      check("fetch_count", fetch_count, Perf ? 32'd4 : 32'd0);

      // Redirect with ihit: immediate, squashes IF/ID
      redirect_valid = 1'b1; redirect_pc = 32'h10; ihit = 1'b1;
      step();
      check("rd_now_addr", imemaddr, 32'h10);
      check("rd_now_valid", {31'b0, if_valid}, 32'd0);
      check("rd_now_instr", if_instr, 32'h0);
      // Redirect without ihit, then a newer one; old address held until ihit
      redirect_pc = 32'h40; ihit = 1'b0;
      step();
      check("rd_pend1_addr", imemaddr, 32'h10);
      check("rd_pend1_valid", {31'b0, if_valid}, 32'd0);
      redirect_pc = 32'h83; // low bits dropped
      step();
      check("rd_pend2_addr", imemaddr, 32'h10);
      redirect_valid = 1'b0; stall = 1'b1; halt_in = 1'b1; // ignored while pending
      step();
      check("rd_pend3_addr", imemaddr, 32'h10);
      check("rd_pend3_valid", {31'b0, if_valid}, 32'd0);
      check("rd_pend3_halted", {31'b0, halted}, 32'd0);
      stall = 1'b0; halt_in = 1'b0; ihit = 1'b1; imemload = 32'hDEADBEEF;
      step();
      check("rd_done_addr", imemaddr, 32'h80);
      check("rd_done_valid", {31'b0, if_valid}, 32'd0);
      imemload = 32'h33333333;
      step();
      check("rd_tgt_instr", if_instr, 32'h33333333);
      check("rd_tgt_npc", if_npc, 32'h84);

      // Redirect beats halt
      halt_in = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
      step();
      check("hr_addr", imemaddr, 32'h200);
      check("hr_halted", {31'b0, halted}, 32'd0);
      redirect_valid = 1'b0;
      step();
      check("halt_halted", {31'b0, halted}, 32'd1);
      check("halt_ren", {31'b0, imemREN}, 32'd0);
      check("halt_valid", {31'b0, if_valid}, 32'd0);
      halt_in = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h300;
      step(); step();
      check("halted_sticky", {31'b0, halted}, 32'd1);
      check("halted_pc", imemaddr, 32'h200);
      check("halted_fcnt", fetch_count, Perf ? 32'd5 : 32'd0);
      redirect_valid = 1'b0; RST = 1'b1;
      step();
      check("rst2_halted", {31'b0, halted}, 32'd0);
      check("rst2_addr", imemaddr, 32'h100);
      check("rst2_ren", {31'b0, imemREN}, 32'd1);
      check("rst2_fcnt", fetch_count, 32'h0);

      // PC wrap
      RST = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFFC;
      step();
      check("wrap_addr0", imemaddr, 32'hFFFFFFFC);
      redirect_valid = 1'b0; imemload = 32'h44444444;
      step();
      check("wrap_instr", if_instr, 32'h44444444);
      check("wrap_npc", if_npc, 32'h0);
      check("wrap_addr", imemaddr, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
